pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen.sv | 150 +++++++++++++++
 tb/tb_pulse_train_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: multi-channel programmable pulse train generator.
//
// Each channel holds shadow configuration registers (mode, high, low, count)
// written through a shared config port. A start request copies the shadows
// into working registers and launches a HIGH/LOW sequence:
//   mode 00 single     : one HIGH phase, then done strobe
//   mode 01 burst      : count pulses of HIGH/LOW, no trailing LOW, then done
//   mode 10 continuous : HIGH/LOW forever until stop, never done
//   mode 11 disabled   : start ignored
//
// Ports:
//   clock     - sole clock, rising edge
//   reset     - synchronous, active-high
//   cfg_we    - config write strobe
//   cfg_ch    - channel addressed by the config write
//   cfg_mode  - channel mode
//   cfg_high  - high-phase length in cycles (0 treated as 1)
//   cfg_low   - low-phase length in cycles (0 treated as 1)
//   cfg_count - pulses per burst (0 treated as 1)
//   start     - per-channel start request, level-sampled
//   stop      - per-channel abort request, wins over start
//   signal    - registered pulse outputs
//   busy      - channel in HIGH or LOW
//   done      - one-cycle completion strobe
module pulse_train_gen #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [ChW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_high,
  input  logic [WIDTH-1:0]    cfg_low,
  input  logic [WIDTH-1:0]    cfg_count,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam logic [1:0] ModeSingle = 2'b00;
  localparam logic [1:0] ModeBurst  = 2'b01;
  localparam logic [1:0] ModeCont   = 2'b10;
  localparam logic [1:0] ModeOff    = 2'b11;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  // Zero-length fields behave as one, so clamp once at start time.
  function automatic logic [WIDTH-1:0] at_least_one(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       sh_mode_q;
    logic [WIDTH-1:0] sh_high_q, sh_low_q, sh_count_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] high_q, low_q, count_q;
    // phase_q counts 1..len inclusive so len = 2^WIDTH-1 never wraps.
    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] pulse_q;
    state_e           state_q;
    logic             done_q;
    logic             sel;

    assign sel = cfg_we && (cfg_ch == ChW'(g));

    always_ff @(posedge clock) begin
      if (reset) begin
        sh_mode_q  <= ModeOff;
        sh_high_q  <= '0;
        sh_low_q   <= '0;
        sh_count_q <= '0;
        mode_q     <= ModeOff;
        high_q     <= '0;
        low_q      <= '0;
        count_q    <= '0;
        phase_q    <= '0;
        pulse_q    <= '0;
        state_q    <= StIdle;
        done_q     <= 1'b0;
      end else begin
        // Shadows only; a running sequence keeps its working copy.
        if (sel) begin
          sh_mode_q  <= cfg_mode;
          sh_high_q  <= cfg_high;
          sh_low_q   <= cfg_low;
          sh_count_q <= cfg_count;
        end

        done_q <= 1'b0;

        if (stop[g]) begin
          state_q <= StIdle;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (start[g] && (sh_mode_q != ModeOff)) begin
                mode_q  <= sh_mode_q;
                high_q  <= at_least_one(sh_high_q);
                low_q   <= at_least_one(sh_low_q);
                count_q <= at_least_one(sh_count_q);
                phase_q <= WIDTH'(1);
                pulse_q <= WIDTH'(1);
                state_q <= StHigh;
              end
            end
            StHigh: begin
              if (phase_q == high_q) begin
                phase_q <= WIDTH'(1);
                if ((mode_q == ModeCont) ||
                    ((mode_q == ModeBurst) && (pulse_q != count_q))) begin
                  state_q <= StLow;
                end else begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                end
              end else begin
                phase_q <= phase_q + WIDTH'(1);
              end
            end
            StLow: begin
              if (phase_q == low_q) begin
                phase_q <= WIDTH'(1);
                if (mode_q == ModeBurst) begin
                  pulse_q <= pulse_q + WIDTH'(1);
                end
                state_q <= StHigh;
              end else begin
                phase_q <= phase_q + WIDTH'(1);
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end

    assign signal[g] = (state_q == StHigh);
    assign busy[g]   = (state_q != StIdle);
    assign done[g]   = done_q;

    logic unused_single;
    assign unused_single = (mode_q == ModeSingle);
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: the stimulus process pushes expected
// {signal, busy, done} per channel and cycle; the monitor checks each cycle.
module tb_pulse_train_gen;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned WIDTH    = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                cfg_we;
  logic [1:0]          cfg_ch;
  logic [1:0]          cfg_mode;
  logic [WIDTH-1:0]    cfg_high, cfg_low, cfg_count;
  logic [CHANNELS-1:0] start, stop;
  logic [CHANNELS-1:0] signal, busy, done;

  pulse_train_gen #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_high (cfg_high),
    .cfg_low  (cfg_low),
    .cfg_count(cfg_count),
    .start    (start),
    .stop     (stop),
    .signal   (signal),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         ch;
    logic [2:0] sbd;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Keep the queue ordered by cycle so the monitor can pop from the front.
  task automatic ex(input int t, input int ch, input logic [2:0] v, input string nm);
    exp_t e;
    int   i;
    e.cyc  = t;
    e.ch   = ch;
    e.sbd  = v;
    e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= t) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clock) begin
    exp_t       e;
    logic [2:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = {signal[e.ch], busy[e.ch], done[e.ch]};
      n_vec++;
      if (e.cyc != cyc || act !== e.sbd) begin
        n_err++;
        $display("FAIL %s cyc=%0d ch=%0d got sig/busy/done=%b expected %b (check cycle %0d)",
                 e.name, cyc, e.ch, act, e.sbd, e.cyc);
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue_start(input logic [CHANNELS-1:0] m);
    start = m;
    goto(cyc + 1);
    start = '0;
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] m, input int h, input int l,
                           input int c);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = m;
    cfg_high  = WIDTH'(h);
    cfg_low   = WIDTH'(l);
    cfg_count = WIDTH'(c);
    goto(cyc + 1);
    cfg_we = 1'b0;
  endtask

  logic [7:0] burst_pat;

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_high = '0; cfg_low = '0; cfg_count = '0; start = '0; stop = '0;
    burst_pat = 8'b11011011;

    // Reset overrides start and config writes.
    for (int t = 1; t <= 3; t++)
      for (int c = 0; c < 4; c++) ex(t, c, 3'b000, "reset");
    goto(1);
    start = '1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b00; cfg_high = 8'd3;
    goto(2);
    start = '0; cfg_we = 1'b0;
    goto(3);
    reset = 1'b0;

    // Default shadow mode is disabled.
    goto(4);
    ex(5, 0, 3'b000, "start_mode11"); ex(6, 0, 3'b000, "start_mode11");
    issue_start(4'b0001);

    goto(6);
    cfg_write(0, 2'b00, 3, 0, 0);
    cfg_write(1, 2'b01, 2, 1, 3);
    cfg_write(2, 2'b10, 1, 1, 0);

    // Single pulse.
    goto(10);
    for (int t = 11; t <= 13; t++) ex(t, 0, 3'b110, "single");
    ex(14, 0, 3'b001, "single_done"); ex(15, 0, 3'b000, "single_idle");
    issue_start(4'b0001);
    n_vec++;
    if (signal[0] !== 1'b1 || busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL direct single cyc=%0d sig=%b busy=%b", cyc, signal[0], busy[0]);
    end

    // Burst, with an extra start during HIGH that must be ignored.
    goto(20);
    for (int t = 21; t <= 28; t++) ex(t, 1, {burst_pat[28 - t], 2'b10}, "burst");
    ex(29, 1, 3'b001, "burst_done"); ex(30, 1, 3'b000, "burst_idle");
    issue_start(4'b0010);
    n_vec++;
    if (signal[1] !== 1'b1) begin
      n_err++;
      $display("FAIL direct burst cyc=%0d sig=%b", cyc, signal[1]);
    end
    goto(22);
    issue_start(4'b0010);

    // Continuous until stop.
    goto(35);
    for (int t = 36; t <= 42; t++)
      ex(t, 2, ((t - 36) % 2 == 0) ? 3'b110 : 3'b010, "continuous");
    for (int t = 43; t <= 45; t++) ex(t, 2, 3'b000, "cont_stop");
    issue_start(4'b0100);
    n_vec++;
    if (signal[2] !== 1'b1) begin
      n_err++;
      $display("FAIL direct continuous cyc=%0d sig=%b", cyc, signal[2]);
    end
    goto(42);
    stop = 4'b0100;
    goto(43);
    stop = '0;
    n_vec++;
    if (signal[2] !== 1'b0 || busy[2] !== 1'b0) begin
      n_err++;
      $display("FAIL direct stop cyc=%0d sig=%b busy=%b", cyc, signal[2], busy[2]);
    end

    // Zero lengths behave as one.
    goto(50);
    cfg_write(3, 2'b01, 0, 0, 0);
    goto(52);
    ex(53, 3, 3'b110, "zero_len"); ex(54, 3, 3'b001, "zero_done"); ex(55, 3, 3'b000, "zero_idle");
    issue_start(4'b1000);

    // Reconfig while busy only affects the next start.
    goto(56);
    cfg_write(3, 2'b00, 4, 0, 0);
    goto(58);
    for (int t = 59; t <= 62; t++) ex(t, 3, 3'b110, "reconfig_busy");
    ex(63, 3, 3'b001, "reconfig_done"); ex(64, 3, 3'b000, "reconfig_idle");
    issue_start(4'b1000);
    goto(60);
    cfg_write(3, 2'b00, 5, 0, 0);
    goto(65);
    for (int t = 66; t <= 70; t++) ex(t, 3, 3'b110, "new_shadow");
    ex(71, 3, 3'b001, "new_shadow_done"); ex(72, 3, 3'b000, "new_shadow_idle");
    issue_start(4'b1000);

    // Stop and start together in IDLE: stop wins.
    goto(75);
    ex(76, 0, 3'b000, "stop_start"); ex(77, 0, 3'b000, "stop_start");
    start = 4'b0001; stop = 4'b0001;
    goto(76);
    start = '0; stop = '0;

    // Simultaneous starts on two channels.
    goto(80);
    for (int t = 81; t <= 83; t++) ex(t, 0, 3'b110, "simul_ch0");
    ex(84, 0, 3'b001, "simul_ch0_done");
    for (int t = 81; t <= 88; t++) ex(t, 1, {burst_pat[88 - t], 2'b10}, "simul_ch1");
    ex(89, 1, 3'b001, "simul_ch1_done");
    issue_start(4'b0011);

    // Reset in the middle of a burst.
    goto(90);
    cfg_write(1, 2'b01, 2, 1, 4);
    goto(100);
    ex(101, 1, 3'b110, "pre_reset"); ex(102, 1, 3'b110, "pre_reset");
    ex(103, 1, 3'b010, "pre_reset"); ex(104, 1, 3'b110, "pre_reset");
    for (int t = 105; t <= 113; t++) ex(t, 1, 3'b000, "reset_mid");
    for (int c = 0; c < 4; c++) if (c != 1) ex(105, c, 3'b000, "reset_mid_all");
    issue_start(4'b0010);
    goto(104);
    reset = 1'b1;
    goto(105);
    reset = 1'b0;
    n_vec++;
    if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
      n_err++;
      $display("FAIL direct reset_mid cyc=%0d busy=%b done=%b", cyc, busy[1], done[1]);
    end

    // Shadows back to disabled: starts ignored.
    goto(108);
    for (int c = 0; c < 4; c++) begin
      if (c != 1) begin
        ex(109, c, 3'b000, "off_after_reset"); ex(110, c, 3'b000, "off_after_reset");
      end
    end
    issue_start(4'b1111);

    // Full-scale high phase must not wrap.
    goto(115);
    cfg_write(2, 2'b00, 255, 0, 0);
    goto(117);
    ex(118, 2, 3'b110, "max_high"); ex(250, 2, 3'b110, "max_high");
    ex(372, 2, 3'b110, "max_high_last"); ex(373, 2, 3'b001, "max_high_done");
    ex(374, 2, 3'b000, "max_high_idle");
    issue_start(4'b0100);

    goto(380);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s never checked: cycle %0d ch=%0d expected %b", e.name, e.cyc, e.ch, e.sbd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
